multicycle_mem: RTL and testbench
=================================

# multicycle_mem

Multi-cycle memory responder serving the cpu's load/store and instruction-fetch requests over a valid/ready request/response handshake. It accepts one request at a time, holds it for a fixed latency, then commits the write or returns the read word and holds the response until the cpu takes it. It sits beside the register file under the cpu top and is the target end of the cpu's memory interface.

## Interface

- ADDR_W, 16, byte-address width from the cpu.
- DATA_W, 16, data word width.
- DEPTH_LOG2, 10, log2 of the number of words in the array.
- LATENCY, 4, cycles from request acceptance to first rsp_valid; legal range 1..15.

- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  one clock; reset is synchronous and active-high.
- req_valid  input  1  cpu presents a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_wr  input  1  1 = store, 0 = load/fetch.
- req_addr  input  ADDR_W  byte address; bit 0 ignored.
- req_wdata  input  DATA_W  store data.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  cpu accepts the response.
- rsp_rdata  output  DATA_W  read word; 0 for store acknowledgements.
- busy  output  1  a request is in flight (state != IDLE).

## Operation

- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, latch req_wr, word index = req_addr[DEPTH_LOG2:1] (upper address bits ignored, so addresses wrap modulo 2^DEPTH_LOG2 words), and req_wdata. Go to WAIT with the latency counter loaded, or go directly to RESP when LATENCY=1.
- WAIT: req_ready=0. Decrement the counter. Enter RESP so that rsp_valid first rises exactly LATENCY cycles after the accept edge.
- Entering RESP: a store writes the array on that edge and rsp_rdata=0. A load captures the array word into rsp_rdata on that edge.
- RESP: rsp_valid=1 and rsp_rdata stay stable until rsp_valid & rsp_ready. Then go to IDLE.
- No request bypass: req_ready is 0 in the cycle a response is accepted. The earliest next accept is the following cycle.
- req_* inputs are ignored outside IDLE. Response data depends only on the latched request.
- The counter is 4 bits. Its width is fixed by the LATENCY range.

## Timing

- Reset values: state=IDLE, req_ready=1 from the first post-reset cycle, rsp_valid=0, rsp_rdata=0, busy=0, counter=0.
- Array contents are not affected by reset.
- Accept at edge E, LATENCY=L: rsp_valid is high from cycle E+L. Back-to-back requests with rsp_ready tied high have a throughput of one request per L+1 cycles.
- rsp_ready held low: rsp_valid stays high indefinitely with no change to rsp_rdata.
- rsp_ready high while rsp_valid=0: no effect.
- Reset mid-operation (WAIT or RESP): return to IDLE next cycle. A store still in WAIT is discarded and never written. A store already in RESP is already committed.
- Simultaneous rst and req_valid: reset wins and the request is not accepted.
- Store then load to the same address: the load returns the new data, because the commit precedes any later accept.

## Structure

- Package wisc_mem_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - default widths ADDR_W/DATA_W;
  - the latency counter width constant (4).
- Sub-module mem_array: single-port synchronous RAM with 2^DEPTH_LOG2 × DATA_W words, write enable, and a registered read. multicycle_mem drives it only on the RESP-entry edge.
- The FSM, counter and request latches live in multicycle_mem.

## Test plan

- Reset, then store addr 0x0010, data 0xBEEF, with rsp_ready=1: req_ready drops the cycle after accept, rsp_valid rises 4 cycles after the accept edge, and rsp_rdata=0x0000. Then load 0x0010 returns 0xBEEF 4 cycles after its accept.
- Address aliasing: store 0x1234 to addr 0x0011, then load addr 0x0010 → 0x1234 (bit 0 ignored). Store 0x5A5A to addr 0x0802, then load 0x0002 → 0x5A5A (wrap at 1024 words).
- Response backpressure: load with rsp_ready=0 for 6 cycles. rsp_valid and rsp_rdata are stable throughout, and req_ready=0 with a new req_valid ignored. Raise rsp_ready: IDLE the next cycle.
- Reset mid-store: store 0xAAAA to 0x0040, assert rst 2 cycles after accept. All outputs return to their reset values next cycle. A subsequent load of 0x0040 returns the prior contents (preloaded 0x1111).
- LATENCY=1 instance: load accepted at edge E gives rsp_valid in cycle E+1. Back-to-back loads with rsp_ready=1 yield one response every 2 cycles.
- Simultaneous rst and req_valid in IDLE: no accept, and rsp_valid stays 0 for 10 cycles.

Source files
------------

// File: rtl/wisc_mem_pkg.sv
// Shared types and default widths for the cpu-side multi-cycle memory responder.
package wisc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 16;

  // LATENCY is limited to 1..15, so a 4-bit down-counter always suffices.
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, write-enable plus registered read.
// Contents are deliberately not reset.
module mem_array #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  // Write port and registered read share the single address.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/multicycle_mem.sv
// Multi-cycle memory responder: one request in flight, fixed latency from
// accept to response, response held until the cpu takes it.
module multicycle_mem
  import wisc_mem_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy
);

  // WAIT lasts LATENCY-1 cycles; RESP is entered on the last WAIT edge so
  // rsp_valid is up LATENCY cycles after the accept edge.
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 1);
  localparam bit               DIRECT   = (LATENCY == 1);

  state_t                  state, state_nx;
  logic [CNT_W-1:0]        cnt, cnt_nx;
  logic                    accept, enter_resp;

  logic                    lat_wr;
  logic [DEPTH_LOG2-1:0]   lat_idx;
  logic [DATA_W-1:0]       lat_wdata;

  logic                    use_wr;
  logic                    mem_we, mem_re;
  logic [DEPTH_LOG2-1:0]   mem_addr;
  logic [DATA_W-1:0]       mem_wdata, mem_rdata;

  // Upper address bits and the byte bit are ignored: word addresses wrap.
  logic                    unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[ADDR_W-1:DEPTH_LOG2+1], req_addr[0]};

  // Next-state, counter and RAM-commit decode; reset overrides everything.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: if (req_valid) begin
        accept = 1'b1;
        if (DIRECT) begin
          state_nx   = RESP;
          enter_resp = 1'b1;
        end else begin
          state_nx = WAIT;
          cnt_nx   = LAT_LOAD;
        end
      end
      WAIT: begin
        cnt_nx = cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          state_nx   = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (rst) begin
      state_nx   = IDLE;
      cnt_nx     = '0;
      accept     = 1'b0;
      enter_resp = 1'b0;
    end
  end

  // State and latency counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Request latches; only loaded on accept so later req_* wiggles are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_wr    <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      lat_wr    <= req_wr;
      lat_idx   <= req_addr[DEPTH_LOG2:1];
      lat_wdata <= req_wdata;
    end
  end

  // With LATENCY=1 the RAM access happens on the accept edge itself, so the
  // live request drives the RAM from IDLE; otherwise the latched copy does.
  assign use_wr    = (state == IDLE) ? req_wr                 : lat_wr;
  assign mem_addr  = (state == IDLE) ? req_addr[DEPTH_LOG2:1] : lat_idx;
  assign mem_wdata = (state == IDLE) ? req_wdata              : lat_wdata;
  assign mem_we    = enter_resp &  use_wr;
  assign mem_re    = enter_resp & ~use_wr;

  mem_array #(
    .DATA_W    (DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .re   (mem_re),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

  // The RAM read register only updates on a load's RESP entry, so it holds
  // steady for the whole response; stores and idle present zero.
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = (rsp_valid && !lat_wr) ? mem_rdata : '0;
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_multicycle_mem.sv
// Randomized scoreboard bench: LATENCY=4 and LATENCY=1 instances share clk/rst.
module tb_multicycle_mem;

  localparam int NI   = 2;
  localparam int LAT0 = 4;
  localparam int LAT1 = 1;

  typedef struct {
    logic        wr;
    logic [9:0]  idx;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          acc;
    bit          b2b;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid [NI];
  logic        req_ready [NI];
  logic        req_wr    [NI];
  logic [15:0] req_addr  [NI];
  logic [15:0] req_wdata [NI];
  logic        rsp_valid [NI];
  logic        rsp_ready [NI];
  logic [15:0] rsp_rdata [NI];
  logic        busy      [NI];

  exp_t        q0[$];
  exp_t        q1[$];
  logic [15:0] model [NI][1024];
  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  bit          held    [NI];
  bit          hs_prev [NI];
  logic [15:0] hold_d  [NI];
  int          last_rise [NI];
  bit          rr_rand [NI];
  logic        rr_val  [NI];
  logic [9:0]  pool    [8];

  multicycle_mem #(.LATENCY(LAT0)) u_l4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wr(req_wr[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .busy(busy[0])
  );

  multicycle_mem #(.LATENCY(LAT1)) u_l1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wr(req_wr[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .busy(busy[1])
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input int s);
    return (s == 0) ? LAT0 : LAT1;
  endfunction

  function automatic int qsize(input int s);
    return (s == 0) ? q0.size() : q1.size();
  endfunction

  task automatic chk(input string name, input int s, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc=%0d got=%h want=%h", name, s, cyc, act, exp);
    end
  endtask

  // Monitor: on each response rise pop the expectation, check latency/data,
  // then watch stability under backpressure and the idle cycle after handshake.
  task automatic mon(input int s);
    exp_t e;
    if (rst) begin
      held[s]    = 1'b0;
      hs_prev[s] = 1'b0;
      return;
    end
    if (hs_prev[s]) begin
      chk("idle_after_hs", s, {29'd0, rsp_valid[s], req_ready[s], busy[s]}, 32'b010);
      hs_prev[s] = 1'b0;
    end
    if (rsp_valid[s]) begin
      chk("no_accept_in_resp", s, {30'd0, req_ready[s], busy[s]}, 32'b01);
      if (!held[s]) begin
        chk("outstanding", s, qsize(s), 1);
        if (qsize(s) > 0) begin
          e = (s == 0) ? q0.pop_front() : q1.pop_front();
          chk("latency", s, cyc - e.acc + 1, lat(s));
          chk("rdata", s, {16'd0, rsp_rdata[s]}, {16'd0, e.rdata});
          if (e.b2b) chk("b2b_gap", s, cyc - last_rise[s], 2);
          if (e.wr) model[s][e.idx] = e.wdata;
        end
        last_rise[s] = cyc;
        held[s]      = 1'b1;
        hold_d[s]    = rsp_rdata[s];
      end else begin
        chk("rdata_stable", s, {16'd0, rsp_rdata[s]}, {16'd0, hold_d[s]});
      end
      if (rsp_ready[s]) begin
        held[s]    = 1'b0;
        hs_prev[s] = 1'b1;
      end
    end
  endtask

  always @(negedge clk) for (int s = 0; s < NI; s++) mon(s);

  // rsp_ready driver: random backpressure or a forced level.
  initial forever begin
    @(posedge clk); #1;
    for (int s = 0; s < NI; s++)
      rsp_ready[s] = rr_rand[s] ? ($urandom_range(0, 3) != 0) : rr_val[s];
  end

  // Issue one request (called at posedge+1); the expectation is computed from
  // the reference memory at the moment the handshake is seen.
  task automatic do_req(input int s, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wd, input bit b2b);
    exp_t e;
    int   n = 0;
    req_valid[s] = 1'b1;
    req_wr[s]    = wr;
    req_addr[s]  = addr;
    req_wdata[s] = wd;
    @(negedge clk);
    while (!req_ready[s]) begin
      n++;
      if (n > 200) begin
        chk("accept_timeout", s, {31'd0, req_ready[s]}, 32'd1);
        req_valid[s] = 1'b0;
        @(posedge clk); #1;
        return;
      end
      @(negedge clk);
    end
    e.wr    = wr;
    e.idx   = addr[10:1];
    e.wdata = wd;
    e.rdata = wr ? 16'h0000 : model[s][addr[10:1]];
    e.acc   = cyc + 1;
    e.b2b   = b2b;
    if (s == 0) q0.push_back(e); else q1.push_back(e);
    @(posedge clk); #1;
    req_valid[s] = 1'b0;
    req_wr[s]    = 1'($urandom);
    req_addr[s]  = 16'($urandom);
    req_wdata[s] = 16'($urandom);
  endtask

  task automatic drain(input int s);
    int n = 0;
    while ((qsize(s) != 0 || rsp_valid[s]) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain", s, {31'd0, (qsize(s) == 0 && !rsp_valid[s])}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outs(input string name);
    for (int s = 0; s < NI; s++)
      chk(name, s, {13'd0, req_ready[s], rsp_valid[s], busy[s], rsp_rdata[s]},
          {13'd0, 1'b1, 1'b0, 1'b0, 16'h0000});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d errors=%0d", cyc, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < NI; s++) begin
      req_valid[s] = 1'b0; req_wr[s] = 1'b0; req_addr[s] = '0; req_wdata[s] = '0;
      rsp_ready[s] = 1'b1; rr_rand[s] = 1'b0; rr_val[s] = 1'b1;
      held[s] = 1'b0; hs_prev[s] = 1'b0; hold_d[s] = '0; last_rise[s] = 0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_outs("reset_state");
    @(posedge clk); #1;

    // Store/load round trip.
    do_req(0, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
    do_req(0, 1'b0, 16'h0010, 16'h0000, 1'b0);
    // Byte bit ignored, upper bits wrap.
    do_req(0, 1'b1, 16'h0011, 16'h1234, 1'b0);
    do_req(0, 1'b0, 16'h0010, 16'h0000, 1'b0);
    do_req(0, 1'b1, 16'h0802, 16'h5A5A, 1'b0);
    do_req(0, 1'b0, 16'h0002, 16'h0000, 1'b0);

    // Reset during a store's wait: store discarded, old word survives.
    do_req(0, 1'b1, 16'h0040, 16'h1111, 1'b0);
    drain(0);
    do_req(0, 1'b1, 16'h0040, 16'hAAAA, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    q0.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outs("reset_mid_store");
    @(posedge clk); #1;
    do_req(0, 1'b0, 16'h0040, 16'h0000, 1'b0);
    drain(0);

    // Backpressure: response held six cycles, a stray store must be ignored.
    rr_val[0] = 1'b0;
    @(posedge clk); #1;
    do_req(0, 1'b0, 16'h0010, 16'h0000, 1'b0);
    req_valid[0] = 1'b1; req_wr[0] = 1'b1; req_addr[0] = 16'h0010; req_wdata[0] = 16'hDEAD;
    repeat (9) @(posedge clk);
    #1 req_valid[0] = 1'b0;
    rr_val[0] = 1'b1;
    drain(0);
    do_req(0, 1'b0, 16'h0010, 16'h0000, 1'b0);
    drain(0);

    // Reset and req_valid together: no accept, nothing comes out.
    rst = 1'b1;
    req_valid[0] = 1'b1; req_wr[0] = 1'b0; req_addr[0] = 16'h0010;
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid[0] = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("rst_vs_req", 0, {30'd0, rsp_valid[0], busy[0]}, 32'd0);
    end
    @(posedge clk); #1;

    // LATENCY=1: store, then back-to-back loads every two cycles.
    do_req(1, 1'b1, 16'h0100, 16'hC0DE, 1'b0);
    do_req(1, 1'b1, 16'h0102, 16'h0F0F, 1'b0);
    do_req(1, 1'b0, 16'h0100, 16'h0000, 1'b0);
    do_req(1, 1'b0, 16'h0102, 16'h0000, 1'b1);
    do_req(1, 1'b0, 16'h0101, 16'h0000, 1'b1);
    do_req(1, 1'b0, 16'h0903, 16'h0000, 1'b1);
    drain(1);

    // Randomized traffic over a small aliased pool with random backpressure.
    for (int i = 0; i < 8; i++) pool[i] = 10'($urandom);
    for (int s = 0; s < NI; s++) begin
      for (int i = 0; i < 8; i++)
        do_req(s, 1'b1, {5'($urandom), pool[i], 1'b0}, 16'($urandom), 1'b0);
      drain(s);
      rr_rand[s] = 1'b1;
    end
    for (int i = 0; i < 160; i++) begin
      int          s;
      logic [15:0] a;
      s = int'($urandom_range(0, 1));
      a = {5'($urandom), pool[$urandom_range(0, 7)], 1'($urandom)};
      do_req(s, 1'($urandom), a, 16'($urandom), 1'b0);
    end
    for (int s = 0; s < NI; s++) begin
      rr_rand[s] = 1'b0;
      rr_val[s]  = 1'b1;
    end
    drain(0);
    drain(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
